fnd_scan_decoder: RTL and testbench

- Receive-side counterpart of the FND display driver. It samples the multiplexed 7-segment bus (fnd_com, fnd_data) and decodes each segment pattern back to BCD.
- It rebuilds the 4-digit frame on screen and hands it to the UART/FIFO path through a valid/ready handshake.
- Used for display loopback checking and for reporting the displayed time over UART.

---
 rtl/fnd_scan_pkg.sv | 33 +++
 rtl/fnd_scan_decoder_if.sv | 22 ++
 rtl/fnd_seg_decode.sv | 39 +++
 rtl/fnd_scan_decoder.sv | 167 ++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fnd_scan_pkg.sv
// Shared constants and helpers for the FND scan decoder: segment patterns,
// decoded code values and digit-select to position mapping.
package fnd_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK = 4'hE;
    localparam logic [3:0] CODE_DOT   = 4'hF;

    // Returns {valid, pos}; valid only for an active-low one-hot select.
    function automatic logic [2:0] com_to_pos(input logic [3:0] com);
        logic [2:0] res;
        case (com)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// Frame hand-off bus between the scan decoder (master) and the UART/FIFO
// consumer (slave): BCD digits, dot flags and a valid/ready handshake.
interface fnd_scan_decoder_if;
    logic [15:0] frame_digits;
    logic [3:0]  frame_dots;
    logic        frame_valid;
    logic        frame_ready;

    modport master (
        output frame_digits,
        output frame_dots,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_digits,
        input  frame_dots,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/fnd_seg_decode.sv
// Combinational 7-segment to BCD decoder. With FND_DOT_CAPTURE_EN defined the
// active-low dp bit is reported and 0x7F with dp lit becomes the dot-only code.
module fnd_seg_decode
    import fnd_scan_pkg::*;
(
    input  logic [7:0] data,
    output logic [3:0] code,
    output logic       is_num,
    output logic       is_err,
    output logic       dp
);

    // Pattern lookup on data[6:0]; dp handling depends on the build option.
    always_comb begin
        code   = CODE_BLANK;
        is_num = 1'b0;
        is_err = 1'b0;
`ifdef FND_DOT_CAPTURE_EN
        dp     = ~data[7];
`else
        dp     = data[7] & 1'b0;
`endif
        case (data[6:0])
            SEG_0:     begin code = 4'd0; is_num = 1'b1; end
            SEG_1:     begin code = 4'd1; is_num = 1'b1; end
            SEG_2:     begin code = 4'd2; is_num = 1'b1; end
            SEG_3:     begin code = 4'd3; is_num = 1'b1; end
            SEG_4:     begin code = 4'd4; is_num = 1'b1; end
            SEG_5:     begin code = 4'd5; is_num = 1'b1; end
            SEG_6:     begin code = 4'd6; is_num = 1'b1; end
            SEG_7:     begin code = 4'd7; is_num = 1'b1; end
            SEG_8:     begin code = 4'd8; is_num = 1'b1; end
            SEG_9:     begin code = 4'd9; is_num = 1'b1; end
            SEG_BLANK: code = dp ? CODE_DOT : CODE_BLANK;
            default:   is_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Samples the multiplexed FND bus, captures stable patterns, rebuilds the
// 4-digit frame and offers it over a valid/ready handshake.
// Optional build macro: FND_DOT_CAPTURE_EN (dp capture into frame_dots).
module fnd_scan_decoder
    import fnd_scan_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 fnd_com,
    input  logic [7:0]                 fnd_data,
    fnd_scan_decoder_if.master         frame_if,
    output logic                       seg_err,
    output logic                       overflow,
    output logic                       link_idle
);

    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_CYCLES);
    localparam logic [STB_W-1:0] STB_FIRE = STB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYCLES);

    logic [3:0]       smp_com_r, hold_com_r;
    logic [7:0]       smp_data_r, hold_data_r;
    logic [STB_W-1:0] stb_cnt_r, stb_cnt_s;
    logic [3:0]       seen_r, seen_s;
    logic [15:0]      digit_sh_r, digit_sh_s;
    logic [3:0]       dot_sh_r, dot_sh_s;
    logic [15:0]      frame_digits_r, frame_digits_s;
    logic [3:0]       frame_dots_r, frame_dots_s;
    logic             frame_valid_r, frame_valid_s;
    logic             seg_err_r, seg_err_s;
    logic             overflow_r, overflow_s;
    logic [CNT_W-1:0] to_cnt_r, to_cnt_s;
    logic             link_idle_r, link_idle_s;

    logic [2:0]       smp_pos_s, hold_pos_s;
    logic             same_s, capture_s, complete_s, slot_free_s;
    logic [3:0]       dec_code_s;
    logic             dec_num_s, dec_err_s, dec_dp_s;

    // hold_* is the newest sample already confirmed by the run counter,
    // so it is the value taken on capture.
    fnd_seg_decode u_seg_decode (
        .data   (hold_data_r),
        .code   (dec_code_s),
        .is_num (dec_num_s),
        .is_err (dec_err_s),
        .dp     (dec_dp_s)
    );

    assign smp_pos_s  = com_to_pos(smp_com_r);
    assign hold_pos_s = com_to_pos(hold_com_r);
    assign same_s     = (smp_com_r == hold_com_r) && (smp_data_r == hold_data_r);
    assign capture_s  = (stb_cnt_r == STB_FIRE) && hold_pos_s[2];

    // Stability run counter and idle-timeout counter.
    always_comb begin
        stb_cnt_s   = stb_cnt_r;
        to_cnt_s    = to_cnt_r;
        link_idle_s = 1'b0;
        seg_err_s   = capture_s && dec_err_s;
        if (!smp_pos_s[2] || !same_s) begin
            stb_cnt_s = {STB_W{1'b0}};
        end else if (stb_cnt_r < STB_MAX) begin
            stb_cnt_s = stb_cnt_r + {{(STB_W-1){1'b0}}, 1'b1};
        end else begin
            stb_cnt_s = stb_cnt_r;
        end
        if (capture_s) begin
            to_cnt_s = {CNT_W{1'b0}};
        end else if (to_cnt_r < TO_MAX) begin
            to_cnt_s = to_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            to_cnt_s = to_cnt_r;
        end
        link_idle_s = !capture_s && (to_cnt_s == TO_MAX);
    end

    // Frame assembly and handshake; a completion clears seen before any
    // simultaneous capture marks its own position again.
    always_comb begin
        seen_s         = seen_r;
        digit_sh_s     = digit_sh_r;
        dot_sh_s       = dot_sh_r;
        frame_digits_s = frame_digits_r;
        frame_dots_s   = frame_dots_r;
        frame_valid_s  = frame_valid_r;
        overflow_s     = 1'b0;
        complete_s     = (seen_r == 4'b1111);
        slot_free_s    = !frame_valid_r || frame_if.frame_ready;
        if (complete_s) begin
            seen_s = 4'b0000;
            if (slot_free_s) begin
                frame_digits_s = digit_sh_r;
                frame_dots_s   = dot_sh_r;
                frame_valid_s  = 1'b1;
                dot_sh_s       = 4'b0000;
            end else begin
                overflow_s = 1'b1;
            end
        end else if (frame_valid_r && frame_if.frame_ready) begin
            frame_valid_s = 1'b0;
        end else begin
            frame_valid_s = frame_valid_r;
        end
        if (capture_s && dec_num_s) begin
            digit_sh_s[{hold_pos_s[1:0], 2'b00} +: 4] = dec_code_s;
            seen_s[hold_pos_s[1:0]]                   = 1'b1;
        end else begin
            seen_s = seen_s;
        end
        if (capture_s && dec_dp_s) begin
            dot_sh_s[hold_pos_s[1:0]] = 1'b1;
        end else begin
            dot_sh_s = dot_sh_s;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            smp_com_r      <= 4'b0000;
            smp_data_r     <= 8'h00;
            hold_com_r     <= 4'b0000;
            hold_data_r    <= 8'h00;
            stb_cnt_r      <= {STB_W{1'b0}};
            seen_r         <= 4'b0000;
            digit_sh_r     <= 16'h0000;
            dot_sh_r       <= 4'b0000;
            frame_digits_r <= 16'h0000;
            frame_dots_r   <= 4'b0000;
            frame_valid_r  <= 1'b0;
            seg_err_r      <= 1'b0;
            overflow_r     <= 1'b0;
            to_cnt_r       <= {CNT_W{1'b0}};
            link_idle_r    <= 1'b0;
        end else begin
            smp_com_r      <= fnd_com;
            smp_data_r     <= fnd_data;
            hold_com_r     <= smp_com_r;
            hold_data_r    <= smp_data_r;
            stb_cnt_r      <= stb_cnt_s;
            seen_r         <= seen_s;
            digit_sh_r     <= digit_sh_s;
            dot_sh_r       <= dot_sh_s;
            frame_digits_r <= frame_digits_s;
            frame_dots_r   <= frame_dots_s;
            frame_valid_r  <= frame_valid_s;
            seg_err_r      <= seg_err_s;
            overflow_r     <= overflow_s;
            to_cnt_r       <= to_cnt_s;
            link_idle_r    <= link_idle_s;
        end
    end

    assign frame_if.frame_digits = frame_digits_r;
    assign frame_if.frame_dots   = frame_dots_r;
    assign frame_if.frame_valid  = frame_valid_r;
    assign seg_err               = seg_err_r;
    assign overflow              = overflow_r;
    assign link_idle             = link_idle_r;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Scoreboard bench for fnd_scan_decoder: expected frames are queued as each
// display pattern sequence is driven and checked when the frame is accepted.
module tb_fnd_scan_decoder;

    localparam int TO = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;
    logic       seg_err, overflow, link_idle;
    logic       ready;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err_pulse = 0;
    int n_ovf_pulse = 0;
    int n_acc = 0;
    logic [19:0] exp_q[$];

    fnd_scan_decoder_if fif ();
    assign fif.frame_ready = ready;

    fnd_scan_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (18)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fnd_com   (fnd_com),
        .fnd_data  (fnd_data),
        .frame_if  (fif.master),
        .seg_err   (seg_err),
        .overflow  (overflow),
        .link_idle (link_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg(input int d);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return {1'b1, t[d]};
    endfunction

    function automatic logic [3:0] com_of(input int p);
        logic [3:0] c;
        c = 4'b0001 << p;
        return ~c;
    endfunction

    task automatic show(input logic [3:0] c, input logic [7:0] d, input int n);
        fnd_com  = c;
        fnd_data = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [15:0] v, input bit push_exp);
        if (push_exp) exp_q.push_back({4'b0000, v});
        for (int p = 0; p < 4; p++) show(com_of(p), seg(int'(v[p*4 +: 4])), 10);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: pulse counters and scoreboard pop on accepted frames.
    always @(negedge clk) begin
        if (reset) begin
            if (seg_err) n_err_pulse++;
            if (overflow) n_ovf_pulse++;
            if (fif.frame_valid && fif.frame_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(fif.frame_digits), 32'hFFFF_FFFF);
                end else begin
                    logic [19:0] e;
                    e = exp_q.pop_front();
                    chk("frame_digits", 32'(fif.frame_digits), 32'(e[15:0]));
                    chk("frame_dots", 32'(fif.frame_dots), 32'(e[19:16]));
                end
            end
        end
    end

    initial begin
        int e0;
        logic [3:0] dots_exp;
        reset    = 1'b0;
        ready    = 1'b1;
        fnd_com  = 4'b1111;
        fnd_data = 8'hFF;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_digits", 32'(fif.frame_digits), 32'd0);
        chk("rst_dots", 32'(fif.frame_dots), 32'd0);
        chk("rst_valid", 32'(fif.frame_valid), 32'd0);
        chk("rst_seg_err", 32'(seg_err), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_link_idle", 32'(link_idle), 32'd0);
        reset = 1'b1;

        // normal frame: 0x99, 0xB0, 0xA4, 0xF9 -> 1234
        exp_q.push_back({4'b0000, 16'h1234});
        show(4'b1110, 8'h99, 10);
        show(4'b1101, 8'hB0, 10);
        show(4'b1011, 8'hA4, 10);
        show(4'b0111, 8'hF9, 10);
        drain();
        chk("link_idle_active", 32'(link_idle), 32'd0);

        // glitch of 8 on position 1 must not be captured
        exp_q.push_back({4'b0000, 16'h7635});
        show(com_of(0), seg(5), 10);
        show(com_of(1), seg(3), 10);
        show(com_of(1), 8'h80, 2);
        show(com_of(2), seg(6), 10);
        show(com_of(3), seg(7), 10);
        drain();

        // bad pattern gives one seg_err; invalid select captures nothing
        e0 = n_err_pulse;
        show(4'b1110, 8'h55, 10);
        chk("seg_err_once", 32'(n_err_pulse), 32'(e0 + 1));
        show(4'b1100, seg(8), 10);
        chk("bad_com_no_err", 32'(n_err_pulse), 32'(e0 + 1));
        show(com_of(1), seg(9), 10);
        show(com_of(2), seg(0), 10);
        show(com_of(3), seg(2), 10);
        chk("seen0_clear", 32'(fif.frame_valid), 32'd0);
        exp_q.push_back({4'b0000, 16'h2091});
        show(com_of(0), seg(1), 10);
        drain();

        // backpressure: second frame overflows, first held
        ready = 1'b0;
        e0 = n_ovf_pulse;
        frame(16'h1234, 1'b1);
        frame(16'h5678, 1'b0);
        chk("overflow_once", 32'(n_ovf_pulse), 32'(e0 + 1));
        chk("held_digits", 32'(fif.frame_digits), 32'h1234);
        chk("held_valid", 32'(fif.frame_valid), 32'd1);
        ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_after_accept", 32'(fif.frame_valid), 32'd0);
        chk("bp_queue", 32'(exp_q.size()), 32'd0);

        // dot on position 2
`ifdef FND_DOT_CAPTURE_EN
        dots_exp = 4'b0100;
`else
        dots_exp = 4'b0000;
`endif
        exp_q.push_back({dots_exp, 16'h4221});
        show(com_of(0), seg(1), 10);
        show(com_of(1), seg(2), 10);
        show(com_of(2), 8'h24, 10);
        show(com_of(2), 8'h7F, 10);
        show(com_of(3), seg(4), 10);
        drain();

        // idle timeout and recovery on the next capture
        show(4'b1111, 8'hFF, TO + 20);
        chk("link_idle_set", 32'(link_idle), 32'd1);
        exp_q.push_back({4'b0000, 16'h9873});
        show(com_of(0), seg(3), 10);
        chk("link_idle_clear", 32'(link_idle), 32'd0);
        show(com_of(1), seg(7), 10);
        show(com_of(2), seg(8), 10);
        show(com_of(3), seg(9), 10);
        drain();

        // reset mid-frame discards the partial frame
        show(com_of(0), seg(1), 10);
        show(com_of(1), seg(1), 10);
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        show(com_of(2), seg(5), 10);
        show(com_of(3), seg(6), 10);
        chk("no_frame_after_reset", 32'(fif.frame_valid), 32'd0);
        exp_q.push_back({4'b0000, 16'h6587});
        show(com_of(0), seg(7), 10);
        show(com_of(1), seg(8), 10);
        drain();

        chk("frames_accepted", 32'(n_acc), 32'd7);
        chk("total_overflow", 32'(n_ovf_pulse), 32'd1);
        chk("total_seg_err", 32'(n_err_pulse), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
